// File: rtl/mr_wb_arbiter_n.sv
// N-master to 1-slave pipelined Wishbone arbiter with round-robin or fixed priority,
// outstanding-strobe tracking with ack/err steering, and an optional bus-timeout watchdog.
module mr_wb_arbiter_n #(
    parameter int NMASTERS        = 2,
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int ARB_MODE        = 0,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT         = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NMASTERS-1:0]      m_cyc_i,
    input  logic [NMASTERS-1:0]      m_stb_i,
    input  logic [NMASTERS-1:0]      m_we_i,
    input  logic [NMASTERS*AW-1:0]   m_adr_i,
    input  logic [NMASTERS*DW-1:0]   m_dat_i,
    input  logic [NMASTERS*DW/8-1:0] m_sel_i,
    output logic [NMASTERS-1:0]      m_ack_o,
    output logic [NMASTERS-1:0]      m_err_o,
    output logic [NMASTERS-1:0]      m_stall_o,
    output logic [DW-1:0]            m_dat_o,
    output logic                     s_cyc_o,
    output logic                     s_stb_o,
    output logic                     s_we_o,
    output logic [AW-1:0]            s_adr_o,
    output logic [DW-1:0]            s_dat_o,
    output logic [DW/8-1:0]          s_sel_o,
    input  logic [DW-1:0]            s_dat_i,
    input  logic                     s_ack_i,
    input  logic                     s_err_i,
    input  logic                     s_stall_i,
    output logic [NMASTERS-1:0]      grant_o,
    output logic                     timeout_o
);
    localparam int SW = DW / 8;
    localparam int IW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);
    localparam logic [WW-1:0] WD_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {S_IDLE, S_OWNED} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] last_q, last_d;
    logic [OW-1:0] out_q, out_d;
    logic [WW-1:0] wdog_q, wdog_d;

    logic [IW-1:0] winner, hi_win, lo_win;
    logic          hi_found;
    logic          own_cyc, own_stb, own_we;
    logic [AW-1:0] own_adr;
    logic [DW-1:0] own_dat;
    logic [SW-1:0] own_sel;
    logic          stb_v, rsp_ok, ack_v, err_v, expire;

    // Round-robin: lowest requester above last_owner, else wrap to lowest overall.
    always_comb begin
        hi_win   = '0;
        lo_win   = '0;
        hi_found = 1'b0;
        for (int i = NMASTERS - 1; i >= 0; i--) begin
            if (m_cyc_i[i]) begin
                if (ARB_MODE == 0 && IW'(i) > last_q) begin
                    hi_win   = IW'(i);
                    hi_found = 1'b1;
                end else begin
                    lo_win = IW'(i);
                end
            end
        end
        winner = hi_found ? hi_win : lo_win;
    end

    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        for (int i = 0; i < NMASTERS; i++) begin
            if (owner_q == IW'(i)) begin
                own_cyc = m_cyc_i[i];
                own_stb = m_stb_i[i];
                own_we  = m_we_i[i];
                own_adr = m_adr_i[i*AW +: AW];
                own_dat = m_dat_i[i*DW +: DW];
                own_sel = m_sel_i[i*SW +: SW];
            end
        end
    end

    assign m_dat_o = s_dat_i;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        out_d     = out_q;
        wdog_d    = '0;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        m_ack_o   = '0;
        m_err_o   = '0;
        m_stall_o = '1;
        grant_o   = '0;
        timeout_o = 1'b0;
        stb_v     = 1'b0;
        rsp_ok    = 1'b0;
        ack_v     = 1'b0;
        err_v     = 1'b0;
        expire    = 1'b0;

        case (state_q)
            S_IDLE: begin
                out_d = '0;
                if (|m_cyc_i) begin
                    state_d = S_OWNED;
                    owner_d = winner;
                end
            end
            S_OWNED: begin
                stb_v  = own_stb & (out_q < OUT_MAX);
                rsp_ok = own_cyc & (out_q != '0);
                ack_v  = s_ack_i & rsp_ok;
                err_v  = s_err_i & rsp_ok;
                expire = (TIMEOUT > 0) && rsp_ok && !(ack_v || err_v) && (wdog_q == WD_LAST);

                s_cyc_o   = own_cyc;
                s_stb_o   = stb_v;
                s_we_o    = own_we;
                s_adr_o   = own_adr;
                s_dat_o   = own_dat;
                s_sel_o   = own_sel;
                timeout_o = expire;
                for (int i = 0; i < NMASTERS; i++) begin
                    if (owner_q == IW'(i)) begin
                        grant_o[i]   = 1'b1;
                        m_stall_o[i] = s_stall_i | (out_q == OUT_MAX);
                        m_ack_o[i]   = ack_v;
                        m_err_o[i]   = err_v | expire;
                    end
                end

                case ({stb_v & ~s_stall_i, ack_v | err_v})
                    2'b10:   out_d = out_q + OW'(1);
                    2'b01:   out_d = out_q - OW'(1);
                    default: out_d = out_q;
                endcase

                if (TIMEOUT > 0 && rsp_ok && !(ack_v || err_v))
                    wdog_d = wdog_q + WW'(1);

                if (!own_cyc || expire) begin
                    state_d = S_IDLE;
                    out_d   = '0;
                    wdog_d  = '0;
                    last_d  = owner_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            last_q  <= IW'(NMASTERS - 1);
            out_q   <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            out_q   <= out_d;
            wdog_q  <= wdog_d;
        end
    end

endmodule

// File: tb/tb_mr_wb_arbiter_n.sv
// Scoreboarded bench for mr_wb_arbiter_n: a round-robin instance (MAX_OUTSTANDING=2, TIMEOUT=8)
// and a fixed-priority instance driven by the same masters and slave.
module tb_mr_wb_arbiter_n;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m_cyc, m_stb, m_we;
    logic [63:0] m_adr, m_dat;
    logic [7:0]  m_sel;
    logic [31:0] s_dat;
    logic        s_ack, s_err, s_stall;

    logic [1:0]  m_ack_o, m_err_o, m_stall_o, grant_o;
    logic [31:0] m_dat_o, s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_cyc_o, s_stb_o, s_we_o, timeout_o;

    logic [1:0]  fp_ack, fp_err, fp_stall, fp_grant;
    logic [31:0] fp_mdat, fp_adr, fp_sdat;
    logic [3:0]  fp_sel;
    logic        fp_cyc, fp_stb, fp_we, fp_to;

    int total = 0;
    int bad   = 0;
    int m0_acks = 0;
    int a0;
    int exp_last;
    int e;
    logic [35:0] sb_q[$];
    logic [35:0] exp_rsp;

    always #5 clk = ~clk;

    mr_wb_arbiter_n #(.NMASTERS(2), .AW(32), .DW(32), .ARB_MODE(0),
                      .MAX_OUTSTANDING(2), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_adr_i(m_adr),
        .m_dat_i(m_dat), .m_sel_i(m_sel),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_stall_o(m_stall_o), .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_stall_i(s_stall),
        .grant_o(grant_o), .timeout_o(timeout_o));

    mr_wb_arbiter_n #(.NMASTERS(2), .AW(32), .DW(32), .ARB_MODE(1),
                      .MAX_OUTSTANDING(4), .TIMEOUT(0)) dut_fp (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_adr_i(m_adr),
        .m_dat_i(m_dat), .m_sel_i(m_sel),
        .m_ack_o(fp_ack), .m_err_o(fp_err), .m_stall_o(fp_stall), .m_dat_o(fp_mdat),
        .s_cyc_o(fp_cyc), .s_stb_o(fp_stb), .s_we_o(fp_we), .s_adr_o(fp_adr),
        .s_dat_o(fp_sdat), .s_sel_o(fp_sel),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_stall_i(s_stall),
        .grant_o(fp_grant), .timeout_o(fp_to));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    // Every forwarded ack/err must match the next expected response.
    always @(negedge clk) begin
        #3;
        if (!rst && (|m_ack_o || |m_err_o)) begin
            if (m_ack_o[0]) m0_acks++;
            if (sb_q.size() == 0) begin
                check("sb_unexpected", {m_ack_o, m_err_o}, 4'b0000);
            end else begin
                exp_rsp = sb_q.pop_front();
                check("sb_rsp", {m_ack_o, m_err_o, m_dat_o}, exp_rsp);
            end
        end
    end

    initial begin
        rst = 1'b1;
        m_cyc = '0; m_stb = '0; m_we = '0; m_dat = '0; m_sel = 8'hFF;
        m_adr = {32'h0000_0180, 32'h0000_0100};
        s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0;
        exp_last = 1;

        // reset state
        nxt(); #1;
        check("rst_grant", grant_o, 2'b00);
        check("rst_scyc", {s_cyc_o, s_stb_o, s_we_o}, 3'b000);
        check("rst_sadr", s_adr_o, 32'h0);
        check("rst_stall", m_stall_o, 2'b11);
        check("rst_ackerr", {m_ack_o, m_err_o, timeout_o}, 5'b0);

        // T1: single read by M0
        nxt(); rst = 1'b0;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        #1 check("t1_idle_grant", grant_o, 2'b00);
        nxt(); #1;
        check("t1_grant", grant_o, 2'b01);
        check("t1_sadr", s_adr_o, 32'h100);
        check("t1_sstb_we_sel", {s_stb_o, s_we_o, s_sel_o}, 6'b10_1111);
        check("t1_stall", m_stall_o, 2'b10);
        nxt(); m_stb[0] = 1'b0; s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
        sb_q.push_back({2'b01, 2'b00, 32'hDEAD_BEEF});
        #1 check("t1_ack", {m_ack_o, m_dat_o}, {2'b01, 32'hDEAD_BEEF});
        check("t1_stall1", m_stall_o[1], 1'b1);
        nxt(); s_ack = 1'b0; m_cyc[0] = 1'b0;
        #1 check("t1_scyc_fall", s_cyc_o, 1'b0);
        exp_last = 0;

        // T2: both masters request continuously, one-beat cycles
        for (int r = 0; r < 4; r++) begin
            nxt(); m_cyc = 2'b11; m_stb = 2'b11;
            e = 1 - exp_last;
            #1 check("t2_idle", {s_cyc_o, grant_o}, 3'b000);
            nxt(); #1;
            check("t2_grant", grant_o, 2'b01 << e);
            check("t2_sadr", s_adr_o, (e == 1) ? 32'h180 : 32'h100);
            check("t2_fp_grant", fp_grant, 2'b01);
            nxt(); m_stb[e] = 1'b0; s_ack = 1'b1; s_dat = 32'hA0 + r;
            sb_q.push_back({2'b01 << e, 2'b00, 32'hA0 + r});
            nxt(); s_ack = 1'b0; m_cyc[e] = 1'b0;
            #1 check("t2_release", s_cyc_o, 1'b0);
            exp_last = e;
        end
        nxt(); m_cyc = '0; m_stb = '0;

        // T3: outstanding limit of 2, three strobes
        a0 = m0_acks;
        nxt(); m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[31:0] = 32'h200;
        nxt(); #1 check("t3_s1", {s_stb_o, m_stall_o[0]}, 2'b10);
        nxt(); m_adr[31:0] = 32'h204;
        #1 check("t3_s2", {s_stb_o, m_stall_o[0]}, 2'b10);
        nxt(); m_adr[31:0] = 32'h208;
        #1 check("t3_s3_stall", {s_stb_o, m_stall_o[0]}, 2'b01);
        nxt(); #1 check("t3_s3_hold", {s_stb_o, m_stall_o[0]}, 2'b01);
        nxt(); s_ack = 1'b1; s_dat = 32'h11;
        sb_q.push_back({2'b01, 2'b00, 32'h11});
        #1 check("t3_ack1_stall", m_stall_o[0], 1'b1);
        nxt(); s_ack = 1'b0;
        #1 check("t3_s3_go", {s_stb_o, m_stall_o[0], s_adr_o}, {2'b10, 32'h208});
        nxt(); m_stb[0] = 1'b0; s_ack = 1'b1; s_dat = 32'h22;
        sb_q.push_back({2'b01, 2'b00, 32'h22});
        nxt(); s_dat = 32'h33;
        sb_q.push_back({2'b01, 2'b00, 32'h33});
        nxt(); s_ack = 1'b0; m_cyc[0] = 1'b0;
        nxt(); check("t3_ack_count", m0_acks - a0, 3);
        exp_last = 0;

        // T4: M1 stalls the bus, watchdog expires, waiting M0 granted
        m_cyc = 2'b11; m_stb = 2'b11; m_adr[63:32] = 32'h300;
        nxt(); #1 check("t4_grant", grant_o, 2'b10);
        nxt(); m_stb[1] = 1'b0;
        for (int k = 0; k < 7; k++) begin
            #1 check("t4_no_timeout", {timeout_o, m_err_o}, 3'b000);
            nxt();
        end
        s_dat = 32'h0;
        sb_q.push_back({2'b00, 2'b10, 32'h0});
        #1 check("t4_timeout", {timeout_o, m_err_o}, 3'b110);
        nxt(); m_cyc[1] = 1'b0;
        #1 check("t4_idle", {grant_o, timeout_o}, 3'b000);
        nxt(); #1 check("t4_m0_grant", grant_o, 2'b01);
        nxt(); m_stb[0] = 1'b0; s_ack = 1'b1; s_dat = 32'h44;
        sb_q.push_back({2'b01, 2'b00, 32'h44});
        nxt(); s_ack = 1'b0; m_cyc[0] = 1'b0;
        exp_last = 0;

        // T5: spurious acks are dropped and do not disturb the outstanding count
        nxt(); s_ack = 1'b1;
        #1 check("t5_idle_ack", m_ack_o, 2'b00);
        nxt(); s_ack = 1'b0; m_cyc[0] = 1'b1; m_stb[0] = 1'b0;
        nxt(); s_ack = 1'b1;
        #1 check("t5_owned_ack", {grant_o, m_ack_o}, 4'b0100);
        nxt(); s_ack = 1'b0; s_err = 1'b1;
        #1 check("t5_owned_err", m_err_o, 2'b00);
        nxt(); s_err = 1'b0; m_stb[0] = 1'b1; m_adr[31:0] = 32'h400;
        #1 check("t5_s1", m_stall_o, 2'b10);
        nxt(); #1 check("t5_s2", m_stall_o[0], 1'b0);
        nxt(); #1 check("t5_full", {s_stb_o, m_stall_o[0]}, 2'b01);
        nxt(); m_stb[0] = 1'b0; s_ack = 1'b1; s_dat = 32'h55;
        sb_q.push_back({2'b01, 2'b00, 32'h55});
        nxt(); s_dat = 32'h66;
        sb_q.push_back({2'b01, 2'b00, 32'h66});
        nxt(); s_ack = 1'b0; m_cyc[0] = 1'b0;

        // T6: reset with two strobes outstanding
        nxt(); m_cyc = 2'b11; m_stb = 2'b11;
        nxt(); #1 check("t6_grant", grant_o, 2'b10);
        nxt();
        nxt(); rst = 1'b1;
        #1 check("t6_rst_bus", {s_cyc_o, s_stb_o, grant_o}, 4'b0000);
        check("t6_rst_stall", m_stall_o, 2'b11);
        nxt(); rst = 1'b0;
        nxt(); #1 check("t6_m0_first", grant_o, 2'b01);
        nxt(); m_cyc = '0; m_stb = '0;
        #1 check("t6_release", s_cyc_o, 1'b0);
        nxt(); nxt();
        check("sb_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
